usb_rx_ctrl: RTL and testbench
==============================

// Module: usb_rx_ctrl
// PURPOSE
//  Receive-side sequencer between the USB receiver and the AHB data buffer.
//  Drains payload bytes from the receiver FIFO into the data buffer, counts
//  them and enforces max packet size. Classifies the completed packet from
//  its PID and posts sticky status for the AHB slave.
//  Flushes the receiver FIFO after any error.
// PARAMETERS
//  MAX_PKT  64  max payload bytes per packet
//  CNT_W    7   byte_count width; must hold 0..MAX_PKT
// PORTS
//  clk               in   1      system clock, rising edge
//  rst               in   1      reset; asynchronous, active-high
//  rcving            in   1      receiver: packet in progress
//  r_error           in   1      receiver: bit/EOP/PID error
//  empty             in   1      receiver FIFO empty
//  r_data            in   8      receiver FIFO head (read-ahead; valid while !empty)
//  pid               in   4      receiver: PID of current packet
//  r_enable          out  1      receiver FIFO pop, 1 cycle per byte
//  buf_full          in   1      data buffer cannot accept a byte
//  buf_wr            out  1      data buffer write strobe
//  buf_wdata         out  8      data buffer write data (= r_data)
//  status_clear      in   1      AHB slave: clear sticky status
//  byte_count        out  CNT_W  payload bytes stored for current/last packet
//  rx_packet         out  3      0 none, 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK
//  rx_data_ready     out  1      DATA packet with byte_count>0 stored (sticky)
//  rx_transfer_active out 1      packet being received/drained
//  rx_error          out  1      sticky error flag
//  pkt_done          out  1      1-cycle pulse at packet end (good or bad)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0. FIFO contents are not touched.
//  FSM states: IDLE, ACTIVE, DRAIN, DONE, ERROR.
//  IDLE: rcving=1 -> ACTIVE. Same cycle: byte_count=0, rx_packet=0,
//   rx_data_ready=0, rx_error=0. A new packet start beats status_clear.
//  Transfer rule (ACTIVE, DRAIN): if !empty && !buf_full, then in the same
//   cycle r_enable=1, buf_wr=1, buf_wdata=r_data, and byte_count+1 next
//   cycle. At most one byte per cycle. buf_full stalls with no pop.
//  ACTIVE: r_error=1 -> ERROR, with no transfer that cycle. A transfer
//   eligible with byte_count==MAX_PKT -> ERROR (overflow), with no write.
//   rcving=0 -> DRAIN. A transfer may still occur in that cycle.
//  DRAIN: apply the transfer rule and the same error rules until empty=1
//   -> DONE.
//  DONE (1 cycle): pkt_done=1. Decode pid: 0001->1, 1001->2, 0011/1011->3,
//   0010->4, 1010->5; rx_packet latched. rx_data_ready=(code 3 &&
//   byte_count>0). A token/handshake with byte_count>0, or any other pid,
//   sets rx_error=1 and rx_packet=0 instead. -> IDLE.
//  ERROR: rx_error=1 (sticky). r_enable=!empty (flush) and buf_wr=0.
//   When rcving=0 && empty=1: pkt_done=1 for 1 cycle -> IDLE.
//  rx_transfer_active=1 in ACTIVE, DRAIN, ERROR; 0 in IDLE, DONE.
//  status_clear (in IDLE) zeroes rx_packet, rx_data_ready and rx_error next
//   cycle. byte_count is held until the next packet start.
//  Asserting rst mid-packet aborts immediately. The FSM resumes in IDLE and
//   re-arms on the next rcving=1. Flushing any leftover FIFO data is the
//   receiver reset's job.
// TESTING
//  1 DATA0 (pid 0011), 3 bytes A5,5A,FF, buf never full -> 3 buf_wr in
//    order, byte_count=3, rx_packet=3, rx_data_ready=1, 1 pkt_done.
//  2 ACK (pid 0010), 0 bytes -> rx_packet=4, rx_data_ready=0, no buf_wr,
//    pkt_done pulse.
//  3 DATA1, 4 bytes, buf_full=1 for 5 cycles mid-packet -> no r_enable while
//    full; all 4 bytes are written after release, byte_count=4.
//  4 65-byte DATA0 -> 64 writes, rx_error=1, rest of FIFO flushed with
//    buf_wr=0, one pkt_done.
//  5 r_error=1 after 2 bytes -> ERROR, flush, rx_error=1, rx_packet=0.
//    Then status_clear -> rx_error=0.
//  6 rst pulse during ACTIVE -> all outputs 0 immediately. The next packet
//    (OUT, pid 0001) gives rx_packet=1.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl
//   Receive-side sequencer between the USB receiver and the AHB data buffer.
//   Moves payload bytes from the receiver FIFO into the data buffer, counts
//   them against MAX_PKT, classifies the finished packet from its PID and
//   keeps sticky status for the AHB slave. After any error the receiver FIFO
//   is flushed.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rcving, r_error     receiver packet-in-progress and error indications
//   empty, r_data       receiver FIFO status and read-ahead head byte
//   pid                 PID of the current packet
//   r_enable            receiver FIFO pop
//   buf_full            data buffer back-pressure
//   buf_wr, buf_wdata   data buffer write strobe and data
//   status_clear        clears sticky status while idle
//   byte_count          payload bytes stored for the current/last packet
//   rx_packet           0 none, 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK
//   rx_data_ready       sticky: DATA packet with payload stored
//   rx_transfer_active  packet being received or drained
//   rx_error            sticky error flag
//   pkt_done            one-cycle pulse at packet end
module usb_rx_ctrl #(
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rcving,
    input  logic             r_error,
    input  logic             empty,
    input  logic [7:0]       r_data,
    input  logic [3:0]       pid,
    output logic             r_enable,
    input  logic             buf_full,
    output logic             buf_wr,
    output logic [7:0]       buf_wdata,
    input  logic             status_clear,
    output logic [CNT_W-1:0] byte_count,
    output logic [2:0]       rx_packet,
    output logic             rx_data_ready,
    output logic             rx_transfer_active,
    output logic             rx_error,
    output logic             pkt_done
);

    typedef enum logic [2:0] {IDLE, ACTIVE, DRAIN, DONE, ERROR} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] byte_count_nx;
    logic [2:0]       rx_packet_nx;
    logic             rx_data_ready_nx;
    logic             rx_error_nx;
    logic [2:0]       code;
    logic             eligible;
    logic             at_max;

    always_comb begin
        case (pid)
            4'b0001:          code = 3'd1;
            4'b1001:          code = 3'd2;
            4'b0011, 4'b1011: code = 3'd3;
            4'b0010:          code = 3'd4;
            4'b1010:          code = 3'd5;
            default:          code = 3'd0;
        endcase
    end

    assign eligible = !empty && !buf_full;
    assign at_max   = (byte_count == CNT_W'(MAX_PKT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            byte_count    <= '0;
            rx_packet     <= '0;
            rx_data_ready <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            state         <= state_nx;
            byte_count    <= byte_count_nx;
            rx_packet     <= rx_packet_nx;
            rx_data_ready <= rx_data_ready_nx;
            rx_error      <= rx_error_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        byte_count_nx    = byte_count;
        rx_packet_nx     = rx_packet;
        rx_data_ready_nx = rx_data_ready;
        rx_error_nx      = rx_error;
        r_enable         = 1'b0;
        buf_wr           = 1'b0;
        pkt_done         = 1'b0;
        case (state)
            IDLE: begin
                // A packet start takes priority over status_clear.
                if (rcving) begin
                    state_nx         = ACTIVE;
                    byte_count_nx    = '0;
                    rx_packet_nx     = '0;
                    rx_data_ready_nx = 1'b0;
                    rx_error_nx      = 1'b0;
                end else if (status_clear) begin
                    rx_packet_nx     = '0;
                    rx_data_ready_nx = 1'b0;
                    rx_error_nx      = 1'b0;
                end
            end
            ACTIVE, DRAIN: begin
                if (r_error) begin
                    state_nx = ERROR;
                end else if (eligible && at_max) begin
                    // A byte beyond MAX_PKT is never written; ERROR flushes it.
                    state_nx = ERROR;
                end else begin
                    if (eligible) begin
                        r_enable      = 1'b1;
                        buf_wr        = 1'b1;
                        byte_count_nx = byte_count + 1'b1;
                    end
                    if (state == ACTIVE && !rcving) begin
                        state_nx = DRAIN;
                    end else if (state == DRAIN && empty) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                pkt_done = 1'b1;
                state_nx = IDLE;
                if (code == 3'd0 || (code != 3'd3 && byte_count != '0)) begin
                    rx_error_nx      = 1'b1;
                    rx_packet_nx     = '0;
                    rx_data_ready_nx = 1'b0;
                end else begin
                    rx_packet_nx     = code;
                    rx_data_ready_nx = (code == 3'd3) && (byte_count != '0);
                end
            end
            ERROR: begin
                rx_error_nx = 1'b1;
                r_enable    = !empty;
                if (!rcving && empty) begin
                    pkt_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign buf_wdata          = buf_wr ? r_data : '0;
    assign rx_transfer_active = (state == ACTIVE) || (state == DRAIN) || (state == ERROR);

endmodule

// File: tb/tb_usb_rx_ctrl.sv
module tb_usb_rx_ctrl;

    localparam int MAX_PKT = 64;
    localparam int CNT_W   = 7;

    typedef struct {
        int pkt;
        int rdy;
        int err;
        int bc;
    } res_t;

    logic             clk = 1'b0;
    logic             rst, rcving, r_error, empty, buf_full, status_clear;
    logic [7:0]       r_data;
    logic [3:0]       pid;
    logic             r_enable, buf_wr, rx_data_ready, rx_transfer_active, rx_error, pkt_done;
    logic [7:0]       buf_wdata;
    logic [CNT_W-1:0] byte_count;
    logic [2:0]       rx_packet;

    usb_rx_ctrl #(.MAX_PKT(MAX_PKT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rcving(rcving), .r_error(r_error), .empty(empty),
        .r_data(r_data), .pid(pid), .r_enable(r_enable), .buf_full(buf_full),
        .buf_wr(buf_wr), .buf_wdata(buf_wdata), .status_clear(status_clear),
        .byte_count(byte_count), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [7:0] fifo[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] pkt[$];
    res_t exp_res[$];
    res_t cur;
    bit err_pkt = 0;
    bit chk_pending = 0;
    bit rand_full = 0;
    int full_hold = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected outcome of a packet from its PID, length and error point.
    function automatic res_t model(input logic [3:0] p, input int n, input int err_at);
        res_t r;
        int c;
        case (p)
            4'd1:        c = 1;
            4'd9:        c = 2;
            4'd3, 4'd11: c = 3;
            4'd2:        c = 4;
            4'd10:       c = 5;
            default:     c = 0;
        endcase
        r.pkt = 0; r.rdy = 0; r.err = 1;
        if (err_at >= 0)                 r.bc = err_at;
        else if (n > MAX_PKT)            r.bc = MAX_PKT;
        else if (c == 0 || (c != 3 && n > 0)) r.bc = n;
        else begin
            r.bc = n; r.pkt = c; r.err = 0;
            r.rdy = (c == 3 && n > 0) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic refresh();
        empty  = (fifo.size() == 0);
        r_data = empty ? 8'h00 : fifo[0];
    endtask

    // One clock: sample pop request, advance past the edge, then update the FIFO.
    task automatic step();
        logic pop;
        #1 pop = r_enable;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        if (full_hold > 0) begin
            buf_full = 1'b1;
            full_hold--;
        end else begin
            buf_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        refresh();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (chk_pending) begin
                chk_pending = 0;
                check("rx_packet", int'(rx_packet), cur.pkt);
                check("rx_data_ready", int'(rx_data_ready), cur.rdy);
                check("rx_error", int'(rx_error), cur.err);
                check("byte_count", int'(byte_count), cur.bc);
                check("pkt_done_width", int'(pkt_done), 0);
                check("active_after_done", int'(rx_transfer_active), 0);
            end
            if (buf_wr) begin
                check("wr_while_full", int'(buf_full), 0);
                if (exp_bytes.size() == 0) check("unexpected_wr", 1, 0);
                else check("wr_data", int'(buf_wdata), int'(exp_bytes.pop_front()));
            end
            if (!err_pkt && (r_enable || buf_wr))
                check("pop_eq_wr", int'(r_enable), int'(buf_wr));
            if (pkt_done) begin
                done_cnt++;
                if (exp_res.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    cur = exp_res.pop_front();
                    chk_pending = 1;
                end
            end
        end
    end

    // Sends pkt[0..n-1]; err_at>=0 raises r_error after that many bytes are drained.
    task automatic run_pkt(input logic [3:0] p, input int n, input int err_at,
                           input bit fm, input int hold_at);
        int lim, start, k;
        int stored;
        stored = (err_at >= 0) ? err_at : ((n > MAX_PKT) ? MAX_PKT : n);
        for (int i = 0; i < stored; i++) exp_bytes.push_back(pkt[i]);
        exp_res.push_back(model(p, n, err_at));
        err_pkt   = (err_at >= 0) || (n > MAX_PKT);
        rand_full = fm;
        pid       = p;
        rcving    = 1'b1;
        start     = done_cnt;
        lim       = (err_at >= 0) ? err_at : n;
        for (int i = 0; i < lim; i++) begin
            fifo.push_back(pkt[i]);
            refresh();
            if (i == hold_at) full_hold = 5;
            step();
        end
        if (err_at >= 0) begin
            k = 0;
            while (fifo.size() > 0 && k < 500) begin step(); k++; end
            if (fifo.size() > 0) check("drain_timeout", 0, 1);
            r_error = 1'b1;
            step();
            r_error = 1'b0;
            for (int i = err_at; i < n; i++) begin
                fifo.push_back(pkt[i]);
                refresh();
                step();
            end
        end
        step();
        rcving = 1'b0;
        k = 0;
        while (done_cnt == start && k < 1000) begin step(); k++; end
        if (done_cnt == start) check("pkt_done_timeout", 0, 1);
        rand_full = 0;
        step();
        step();
        err_pkt = 0;
    endtask

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [3:0] pids [9];
        logic [3:0] p;
        int n, e;
        pids = '{4'd1, 4'd9, 4'd3, 4'd11, 4'd2, 4'd10, 4'd0, 4'd4, 4'd15};
        rst = 1'b1; rcving = 0; r_error = 0; buf_full = 0; status_clear = 0; pid = '0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_count", int'(byte_count), 0);
        check("rst_rx_packet", int'(rx_packet), 0);
        check("rst_active", int'(rx_transfer_active), 0);
        check("rst_r_enable", int'(r_enable), 0);
        rst = 1'b0;
        step();

        // DATA0 with A5,5A,FF
        pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h5A); pkt.push_back(8'hFF);
        run_pkt(4'b0011, 3, -1, 0, -1);
        // ACK, no payload
        pkt.delete();
        run_pkt(4'b0010, 0, -1, 0, -1);
        // DATA1, 4 bytes with a 5-cycle buffer stall
        fill_rand(4);
        run_pkt(4'b1011, 4, -1, 0, 1);
        // 64 bytes exactly, then 65 bytes (overflow)
        fill_rand(64);
        run_pkt(4'b0011, 64, -1, 0, -1);
        fill_rand(65);
        run_pkt(4'b0011, 65, -1, 0, -1);
        // receiver error after 2 bytes, then status_clear
        fill_rand(5);
        run_pkt(4'b0011, 5, 2, 0, -1);
        check("err_sticky", int'(rx_error), 1);
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        check("clr_rx_error", int'(rx_error), 0);
        check("clr_rx_packet", int'(rx_packet), 0);
        check("clr_byte_count_held", int'(byte_count), 2);

        // reset in the middle of a packet
        pid = 4'b0011; rcving = 1'b1; full_hold = 50;
        for (int i = 0; i < 3; i++) fifo.push_back(8'(i + 1));
        refresh();
        step();
        step();
        check("mid_active", int'(rx_transfer_active), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_active", int'(rx_transfer_active), 0);
        check("arst_r_enable", int'(r_enable), 0);
        check("arst_buf_wr", int'(buf_wr), 0);
        check("arst_pkt_done", int'(pkt_done), 0);
        check("arst_rx_error", int'(rx_error), 0);
        fifo.delete(); full_hold = 0; rcving = 1'b0; refresh();
        step();
        rst = 1'b0;
        step();
        pkt.delete();
        run_pkt(4'b0001, 0, -1, 0, -1);

        // randomized packets
        for (int t = 0; t < 30; t++) begin
            p = pids[$urandom_range(0, 8)];
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 6));
            e = -1;
            if (n >= 2 && $urandom_range(0, 5) == 0) begin
                e = int'($urandom_range(1, n - 1));
                if (e > MAX_PKT) e = MAX_PKT;
            end
            fill_rand(n);
            run_pkt(p, n, e, $urandom_range(0, 1) == 1, -1);
        end

        check("bytes_left", exp_bytes.size(), 0);
        check("results_left", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
